// File: rtl/complex_upmixer_pkg.sv
// Shared stream types and output range limits for the transmit upmixer
// and the rest of the datapath.
package complex_upmixer_pkg;

   localparam int SAMPLE_W = 18;
   localparam int DATA_W   = 16;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] i;
      logic signed [SAMPLE_W-1:0] q;
      logic                       valid;
   } complex_stream_t;

   typedef struct packed {
      logic signed [DATA_W-1:0] data;
      logic                     valid;
   } data_stream_t;

   localparam logic signed [DATA_W-1:0] DATA_MAX = 16'sd32767;
   localparam logic signed [DATA_W-1:0] DATA_MIN = -16'sd32768;

endpackage

// File: rtl/round_saturate.sv
// Combinational round-half-up by SHIFT followed by a clamp to OUT_W signed
// bits; sat reports that the clamp engaged.
module round_saturate #(
   parameter int IN_W  = 37,
   parameter int SHIFT = 0,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    sat
);

   localparam logic signed [IN_W:0] OUT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] OUT_MIN = ~OUT_MAX;
   // Evaluates to zero when SHIFT is 0, so the helper degenerates to a pure clamp.
   localparam logic signed [IN_W:0] HALF    = ({{IN_W{1'b0}}, 1'b1} << SHIFT) >> 1;

   function automatic logic signed [IN_W:0] round_half_up(input logic signed [IN_W:0] x);
      return (x + HALF) >>> SHIFT;
   endfunction

   function automatic logic signed [OUT_W-1:0] clamp(input logic signed [IN_W:0] x);
      if (x > OUT_MAX)
         return OUT_MAX[OUT_W-1:0];
      else if (x < OUT_MIN)
         return OUT_MIN[OUT_W-1:0];
      else
         return x[OUT_W-1:0];
   endfunction

   logic signed [IN_W:0] rnd;

   always_comb begin
      rnd  = round_half_up({din[IN_W-1], din});
      sat  = (rnd > OUT_MAX) || (rnd < OUT_MIN);
      dout = clamp(rnd);
   end

endmodule

// File: rtl/complex_upmixer.sv
// Transmit upmixer: real passband = I*cos - Q*sin, four register stages with
// half-up rounding, saturation and a sticky, saturating overflow counter.
module complex_upmixer
   import complex_upmixer_pkg::*;
#(
   parameter int SHIFT = 19,
   parameter int CNT_W = 16
) (
   input  logic            ipClk,
   input  logic            ipReset,
   input  complex_stream_t ipBaseband,
   input  complex_stream_t ipNCO,
   input  logic            ipClearOverflow,
   output data_stream_t    opOutput,
   output logic            opOverflow,
   output logic [CNT_W-1:0] opOverflowCount
);

   localparam int PROD_W = 2 * SAMPLE_W;
   localparam int DIFF_W = PROD_W + 1;
   localparam logic signed [DIFF_W-1:0] HALF = DIFF_W'(1) <<< (SHIFT - 1);

   // Difference magnitude stays below 2^36, so adding HALF cannot overflow DIFF_W.
   function automatic logic signed [DIFF_W-1:0] round_half_up(input logic signed [DIFF_W-1:0] d);
      return (d + HALF) >>> SHIFT;
   endfunction

   // The NCO runs continuously; its valid bit carries no information here.
   logic nco_valid_unused;
   assign nco_valid_unused = ipNCO.valid;

   logic signed [SAMPLE_W-1:0] bb_i_p1, bb_q_p1, cos_p1, sin_p1;
   logic                       vld_p1;
   logic signed [PROD_W-1:0]   pi_p2, pq_p2;
   logic                       vld_p2;
   logic signed [DIFF_W-1:0]   diff_p2;
   logic signed [DIFF_W-1:0]   r_p3;
   logic                       vld_p3;
   logic signed [DATA_W-1:0]   sat_data_p3;
   logic                       sat_p3;
   logic signed [DATA_W-1:0]   data_p4;
   logic                       vld_p4;
   logic                       ovf_flag;
   logic [CNT_W-1:0]           ovf_cnt;

   // S1: capture inputs
   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         bb_i_p1 <= '0;
         bb_q_p1 <= '0;
         cos_p1  <= '0;
         sin_p1  <= '0;
         vld_p1  <= 1'b0;
      end else begin
         bb_i_p1 <= ipBaseband.i;
         bb_q_p1 <= ipBaseband.q;
         cos_p1  <= ipNCO.i;
         sin_p1  <= ipNCO.q;
         vld_p1  <= ipBaseband.valid;
      end
   end

   // S2: full-width products; -2^17 * -2^17 = 2^34 still fits in PROD_W
   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         pi_p2  <= '0;
         pq_p2  <= '0;
         vld_p2 <= 1'b0;
      end else begin
         pi_p2  <= bb_i_p1 * cos_p1;
         pq_p2  <= bb_q_p1 * sin_p1;
         vld_p2 <= vld_p1;
      end
   end

   assign diff_p2 = {pi_p2[PROD_W-1], pi_p2} - {pq_p2[PROD_W-1], pq_p2};

   // S3: rounded difference kept at full width
   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         r_p3   <= '0;
         vld_p3 <= 1'b0;
      end else begin
         r_p3   <= round_half_up(diff_p2);
         vld_p3 <= vld_p2;
      end
   end

   round_saturate #(
      .IN_W (DIFF_W),
      .SHIFT(0),
      .OUT_W(DATA_W)
   ) u_clamp (
      .din (r_p3),
      .dout(sat_data_p3),
      .sat (sat_p3)
   );

   // S4: output register and overflow bookkeeping; clear beats a same-edge saturation
   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         data_p4  <= '0;
         vld_p4   <= 1'b0;
         ovf_flag <= 1'b0;
         ovf_cnt  <= '0;
      end else begin
         vld_p4 <= vld_p3;
         if (vld_p3)
            data_p4 <= sat_data_p3;
         if (ipClearOverflow) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
         end else if (vld_p3 && sat_p3) begin
            ovf_flag <= 1'b1;
            if (ovf_cnt != {CNT_W{1'b1}})
               ovf_cnt <= ovf_cnt + 1'b1;
         end
      end
   end

   assign opOutput        = '{data: data_p4, valid: vld_p4};
   assign opOverflow      = ovf_flag;
   assign opOverflowCount = ovf_cnt;

endmodule

// File: tb/tb_complex_upmixer.sv
// Directed bench for complex_upmixer: table of hand-computed vectors plus
// sequences for clear priority, gappy valid, counter ceiling and mid-stream reset.
module tb_complex_upmixer;
   import complex_upmixer_pkg::*;

   localparam int CNT_W   = 4;
   localparam int CNT_TOP = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   complex_stream_t  bb, nco;
   logic             clr;
   data_stream_t     out;
   logic             ovf;
   logic [CNT_W-1:0] cnt;

   always #5 clk = ~clk;

   complex_upmixer #(.SHIFT(19), .CNT_W(CNT_W)) dut (
      .ipClk          (clk),
      .ipReset        (rst_n),
      .ipBaseband     (bb),
      .ipNCO          (nco),
      .ipClearOverflow(clr),
      .opOutput       (out),
      .opOverflow     (ovf),
      .opOverflowCount(cnt)
   );

   typedef struct {
      int    i, q, c, s;
      int    data;
      bit    sat;
      string name;
   } vec_t;

   vec_t vecs[9];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cnt_exp = 0;
   int   ovf_exp = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int i, input int q, input int c, input int s, input logic v);
      bb.i      = i[17:0];
      bb.q      = q[17:0];
      bb.valid  = v;
      nco.i     = c[17:0];
      nco.q     = s[17:0];
      nco.valid = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_sat();
      ovf_exp = 1;
      if (cnt_exp < CNT_TOP) cnt_exp++;
   endtask

   task automatic check_status(input string name);
      check({name, "_ovf"}, int'(ovf), ovf_exp);
      check({name, "_cnt"}, int'(cnt), cnt_exp);
   endtask

   // One isolated sample: output must be absent after edge 3 and present after edge 4.
   task automatic apply_vec(input vec_t v);
      drive(v.i, v.q, v.c, v.s, 1'b1);
      step();
      drive(0, 0, 0, 0, 1'b0);
      step();
      step();
      check({v.name, "_early"}, int'(out.valid), 0);
      step();
      if (v.sat) model_sat();
      check({v.name, "_valid"}, int'(out.valid), 1);
      check({v.name, "_data"}, int'(out.data), v.data);
      check_status(v.name);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{65536, 0, 131071, 0, 16384, 1'b0, "inphase"};
      vecs[1] = '{0, 65536, 0, 131071, -16384, 1'b0, "quadrature"};
      vecs[2] = '{-131072, 0, 131071, 0, -32768, 1'b0, "neg_fullscale"};
      vecs[3] = '{4, 0, 65536, 0, 1, 1'b0, "round_pos_half"};
      vecs[4] = '{0, 4, 0, 65536, 0, 1'b0, "round_neg_half"};
      vecs[5] = '{0, -131072, 0, -131072, -32768, 1'b0, "minmin_sin"};
      vecs[6] = '{-131072, 0, -131072, 0, 32767, 1'b1, "minmin_cos"};
      vecs[7] = '{131071, -131072, 131071, 131071, 32767, 1'b1, "sat_pos"};
      vecs[8] = '{-131072, 131071, 131071, 131071, -32768, 1'b1, "sat_neg"};

      clr   = 1'b0;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 1'b0);

      // Reset held with random valid traffic
      for (int k = 0; k < 6; k++) begin
         drive(int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072,
               int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072, 1'b1);
         step();
         check("rst_valid", int'(out.valid), 0);
         check("rst_data", int'(out.data), 0);
         check("rst_cnt", int'(cnt), 0);
      end
      drive(0, 0, 0, 0, 1'b0);
      rst_n = 1'b1;
      step();

      for (int k = 0; k < 9; k++) apply_vec(vecs[k]);

      // Clear on the same edge as a saturated sample reaches the output
      drive(131071, -131072, 131071, 131071, 1'b1);
      step();
      drive(0, 0, 0, 0, 1'b0);
      step();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      cnt_exp = 0;
      ovf_exp = 0;
      check("clr_valid", int'(out.valid), 1);
      check("clr_data", int'(out.data), 32767);
      check_status("clr");
      step();

      // Alternating valid; invalid slots carry saturating data that must not count
      for (int t = 0; t < 11; t++) begin
         if (t < 8) begin
            if (t % 2 == 1)      drive(131071, -131072, 131071, 131071, 1'b0);
            else if (t % 4 == 0) drive(65536, 0, 131071, 0, 1'b1);
            else                 drive(131071, -131072, 131071, 131071, 1'b1);
         end else begin
            drive(0, 0, 0, 0, 1'b0);
         end
         step();
         if (t < 3) begin
            check("gap_pre_valid", int'(out.valid), 0);
         end else begin
            int j, jj;
            j  = t - 3;
            jj = j - (j % 2);
            if (j % 2 == 0 && jj % 4 == 2) model_sat();
            check($sformatf("gap%0d_valid", j), int'(out.valid), (j % 2 == 0) ? 1 : 0);
            check($sformatf("gap%0d_data", j), int'(out.data), (jj % 4 == 0) ? 16384 : 32767);
            check_status($sformatf("gap%0d", j));
         end
      end

      // Counter ceiling
      for (int k = 0; k < 20; k++) begin
         drive(-131072, 131071, 131071, 131071, 1'b1);
         step();
         if (k >= 3) model_sat();
      end
      drive(0, 0, 0, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step();
         if (k < 3) model_sat();
      end
      check("ceil_expect15", cnt_exp, CNT_TOP);
      check_status("ceil");
      check("ceil_data", int'(out.data), -32768);
      check("ceil_valid", int'(out.valid), 0);

      // Reset with three samples in flight
      drive(65536, 0, 131071, 0, 1'b1);
      step();
      drive(0, 65536, 0, 131071, 1'b1);
      step();
      drive(-131072, 0, 131071, 0, 1'b1);
      step();
      drive(0, 0, 0, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      cnt_exp = 0;
      ovf_exp = 0;
      check("midrst_valid", int'(out.valid), 0);
      check("midrst_data", int'(out.data), 0);
      check_status("midrst");
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("midrst_flush_valid", int'(out.valid), 0);
      end
      apply_vec(vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/complex_upmixer.md
Name: complex_upmixer

Overview:
Transmit-side counterpart of the receive downconversion mixer. It takes a complex baseband stream and a complex NCO (cos, sin) and produces a real passband stream: Out = I·cos − Q·sin. The block is a fixed 4-stage pipeline with rounding, saturation and a saturating overflow counter. It sits between the baseband transmit chain and the DAC data stream.

Parameters:
SHIFT, 19, arithmetic right shift applied to the 37-bit difference before saturation (sets the output gain).
CNT_W, 16, width of the overflow counter.

Ports:
ipClk  input  1  system clock; all logic on the rising edge.
ipReset  input  1  reset, asynchronous assert, active-low (0 = reset).
ipBaseband  input  COMPLEX_STREAM  I, Q: 18-bit signed, Q1.17. Valid qualifies each sample.
ipNCO  input  COMPLEX_STREAM  I = cos, Q = sin: 18-bit signed, Q1.17. Valid is always high and is ignored.
ipClearOverflow  input  1  synchronous clear of the overflow counter and flag.
opOutput  output  DATA_STREAM  Data: 16-bit signed real passband sample; Valid.
opOverflow  output  1  sticky flag, set on any saturated valid sample.
opOverflowCount  output  CNT_W  number of saturated valid samples; saturates at all-ones.

Behaviour:
- Reset (ipReset = 0, asynchronous): every pipeline register is 0, opOutput.Data = 0, opOutput.Valid = 0, opOverflow = 0, opOverflowCount = 0.
- No backpressure. The pipeline advances every clock. Valid travels alongside its data.
- S1: register ipBaseband.I, ipBaseband.Q, ipNCO.I, ipNCO.Q and ipBaseband.Valid.
- S2: register the 36-bit signed products PI = I·cos and PQ = Q·sin.
- S3: D = sign-extend(PI) − sign-extend(PQ), 37-bit signed.
  - Round half-up: R = (D + 2^(SHIFT−1)) >>> SHIFT (arithmetic shift).
  - Register R at full width, together with Valid.
- S4: saturate R to [−32768, 32767] and drive opOutput.
- Latency: a sample valid at S1 input on edge n appears on opOutput at edge n+4 with opOutput.Valid = 1.
- When S4 Valid = 0:
  - opOutput.Valid = 0.
  - opOutput.Data holds its last value (no update).
  - The overflow logic is not evaluated.
- Overflow: when S4 Valid = 1 and saturation occurs:
  - opOverflow is set to 1.
  - opOverflowCount increments, but stays at 2^CNT_W−1 once there (no wrap).
- ipClearOverflow = 1 zeroes the counter and flag on that edge. If a saturation happens on the same edge, the clear wins: count = 0, flag = 0.
- Reset mid-stream: all in-flight samples are discarded. The first output after release comes 4 edges after the first valid input.
- The −131072 × −131072 product (+2^34) is representable in 36 bits and must not wrap.

Decomposition:
- Shared Structures package:
  - COMPLEX_STREAM (I, Q 18-bit signed, Valid) and DATA_STREAM (Data 16-bit signed, Valid), reused unchanged.
  - Constants DATA_MAX = 32767 and DATA_MIN = −32768.
- Sub-module round_saturate: a parameterised input width / shift / output width helper for round half-up plus clamp with an overflow flag. It is combinational and is also reused by the decimation filters.
- Pipeline registers, the Valid shift and the overflow counter stay in complex_upmixer.

Test Plan:
- Reset check: hold ipReset = 0 with random inputs -> opOutput.Valid = 0, Data = 0, count = 0. Release, then one valid sample -> Valid = 1 exactly 4 edges later.
- In-phase: I = 65536, Q = 0, cos = 131071, sin = 0 -> Data = 16384, opOverflow = 0.
- Quadrature: I = 0, Q = 65536, cos = 0, sin = 131071 -> Data = −16384. Then I = −131072, Q = 0, cos = 131071 -> Data = −32768, no overflow.
- Saturation: I = 131071, Q = −131072, cos = sin = 131071 -> Data = 32767, opOverflow = 1, count = 1. Then ipClearOverflow on the same edge as a second saturation -> count = 0, flag = 0.
- Gappy valid: alternate ipBaseband.Valid 1/0 over 8 samples -> output Valid pattern identical, delayed 4. Data holds during Valid = 0. Count increments only on valid saturated samples.
- Counter ceiling (CNT_W = 4 build): drive 20 saturating valid samples -> count = 15 and stays 15. Reset mid-stream with 3 samples in flight -> none of the 3 appear on the output.
